// File: rtl/fma_line_writeback.sv
// Line writeback stage: absorbs result lines from fma_write_buffer into a skid FIFO
// and drains them to a line-wide memory port at sequential addresses.
module fma_line_writeback #(
    parameter int LINE_WIDTH = 96,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] base_addr_in,
    input  logic [ADDR_WIDTH-1:0] line_count_in,
    input  logic [LINE_WIDTH-1:0] line_in,
    input  logic                  line_valid_in,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [LINE_WIDTH-1:0] mem_data_out,
    output logic                  mem_we_out,
    input  logic                  mem_ready_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  overflow_out,
    output logic [CNT_W-1:0]      fifo_count_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LINE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      fifo_count_q;
    logic [ADDR_WIDTH-1:0] base_q, count_q, accepted_cnt_q, written_cnt_q;
    logic                  overflow_q;

    logic fifo_full, fifo_empty;
    logic start_accept, push, pop, overflow_evt, last_write;

    assign fifo_full    = (fifo_count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty   = (fifo_count_q == '0);
    assign start_accept = (state_q == IDLE) && start_in;
    assign pop          = !fifo_empty && mem_ready_in;
    // A full FIFO can still take a line in the same cycle its head is written out.
    assign push         = (state_q == RUN) && line_valid_in &&
                          (accepted_cnt_q < count_q) && (!fifo_full || pop);
    assign overflow_evt = (state_q == RUN) && line_valid_in &&
                          ((accepted_cnt_q >= count_q) || (fifo_full && !pop));
    assign last_write   = pop && (written_cnt_q == count_q - ADDR_WIDTH'(1));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_in) state_d = (line_count_in == '0) ? DONE : RUN;
            RUN:  if (last_write) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the line storage has no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= line_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_count_q   <= '0;
            base_q         <= '0;
            count_q        <= '0;
            accepted_cnt_q <= '0;
            written_cnt_q  <= '0;
            overflow_q     <= 1'b0;
        end else begin
            if (start_accept) begin
                base_q         <= base_addr_in;
                count_q        <= line_count_in;
                accepted_cnt_q <= '0;
                written_cnt_q  <= '0;
                overflow_q     <= 1'b0;
            end else begin
                if (push) accepted_cnt_q <= accepted_cnt_q + ADDR_WIDTH'(1);
                if (pop)  written_cnt_q  <= written_cnt_q + ADDR_WIDTH'(1);
                if (overflow_evt) overflow_q <= 1'b1;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    assign mem_we_out     = !fifo_empty;
    // Stale storage is masked so the data bus reads zero whenever nothing is queued.
    assign mem_data_out   = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
    assign mem_addr_out   = base_q + written_cnt_q;
    assign busy_out       = (state_q == RUN);
    assign done_out       = (state_q == DONE);
    assign overflow_out   = overflow_q;
    assign fifo_count_out = fifo_count_q;

endmodule

// File: tb/tb_fma_line_writeback.sv
// Directed self-checking bench for fma_line_writeback with hand-computed expectations.
module tb_fma_line_writeback;

    localparam int LW = 96;
    localparam int AW = 10;
    localparam int FD = 4;
    localparam int CW = $clog2(FD) + 1;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic [AW-1:0] base_addr_in;
    logic [AW-1:0] line_count_in;
    logic [LW-1:0] line_in;
    logic          line_valid_in;
    logic [AW-1:0] mem_addr_out;
    logic [LW-1:0] mem_data_out;
    logic          mem_we_out;
    logic          mem_ready_in;
    logic          busy_out;
    logic          done_out;
    logic          overflow_out;
    logic [CW-1:0] fifo_count_out;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;
    logic [AW-1:0] wr_addr_q[$];
    logic [LW-1:0] wr_data_q[$];

    fma_line_writeback #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .base_addr_in(base_addr_in), .line_count_in(line_count_in),
        .line_in(line_in), .line_valid_in(line_valid_in),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .mem_we_out(mem_we_out), .mem_ready_in(mem_ready_in),
        .busy_out(busy_out), .done_out(done_out), .overflow_out(overflow_out),
        .fifo_count_out(fifo_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Record every accepted memory write and every done pulse, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (rst_in && mem_we_out && mem_ready_in) begin
            wr_addr_q.push_back(mem_addr_out);
            wr_data_q.push_back(mem_data_out);
        end
        if (rst_in && done_out) done_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk_line(input int i);
        return {24'hABCDEF, 8'(i), 32'h1234_0000 + 32'(i), 32'hDEAD_0000 ^ 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] cnt);
        start_in      = 1'b1;
        base_addr_in  = base;
        line_count_in = cnt;
        tick();
        start_in = 1'b0;
    endtask

    task automatic push_lines(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            line_valid_in = 1'b1;
            line_in       = mk_line(first + i);
            tick();
        end
        line_valid_in = 1'b0;
    endtask

    task automatic check_writes(input string tag, input logic [AW-1:0] base, input int n, input int first);
        check({tag, "_nwr"}, 128'(wr_addr_q.size()), 128'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 128'(wr_addr_q[i]), 128'(base + AW'(i)));
            check($sformatf("%s_data%0d", tag, i), 128'(wr_data_q[i]), 128'(mk_line(first + i)));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"},    128'(mem_we_out), 128'(0));
        check({tag, "_done"},  128'(done_out), 128'(0));
        check({tag, "_busy"},  128'(busy_out), 128'(0));
        check({tag, "_ovf"},   128'(overflow_out), 128'(0));
        check({tag, "_addr"},  128'(mem_addr_out), 128'(0));
        check({tag, "_data"},  128'(mem_data_out), 128'(0));
        check({tag, "_count"}, 128'(fifo_count_out), 128'(0));
    endtask

    initial begin
        rst_in = 1'b1; start_in = 1'b0; base_addr_in = '0; line_count_in = '0;
        line_in = '0; line_valid_in = 1'b0; mem_ready_in = 1'b0;
        tick();
        do_reset();
        check_idle_outputs("reset");

        // Basic: base 0x010, four back-to-back lines, memory always ready.
        clear_log();
        mem_ready_in = 1'b1;
        start_job(10'h010, 10'd4);
        check("basic_busy", 128'(busy_out), 128'(1));
        push_lines(1, 0);
        check("basic_lat_we", 128'(mem_we_out), 128'(1));
        check("basic_lat_addr", 128'(mem_addr_out), 128'(10'h010));
        check("basic_lat_data", 128'(mem_data_out), 128'(mk_line(0)));
        push_lines(3, 1);
        check("basic_thru_cnt", 128'(fifo_count_out), 128'(1));
        tick();
        check("basic_done", 128'(done_out), 128'(1));
        check("basic_done_busy", 128'(busy_out), 128'(0));
        tick();
        check("basic_done_gone", 128'(done_out), 128'(0));
        check("basic_ndone", 128'(done_cnt), 128'(1));
        check("basic_ovf", 128'(overflow_out), 128'(0));
        check_writes("basic", 10'h010, 4, 0);

        // Backpressure: fill FIFO with memory stalled, then release.
        clear_log();
        mem_ready_in = 1'b0;
        start_job(10'h100, 10'd4);
        push_lines(4, 10);
        check("bp_count", 128'(fifo_count_out), 128'(4));
        check("bp_we", 128'(mem_we_out), 128'(1));
        tick();
        check("bp_hold_addr", 128'(mem_addr_out), 128'(10'h100));
        check("bp_hold_data", 128'(mem_data_out), 128'(mk_line(10)));
        check("bp_ovf", 128'(overflow_out), 128'(0));
        mem_ready_in = 1'b1;
        ticks(4);
        check("bp_done", 128'(done_out), 128'(1));
        tick();
        check("bp_ndone", 128'(done_cnt), 128'(1));
        check_writes("bp", 10'h100, 4, 10);

        // Overflow: five lines into a four-deep stalled FIFO on an eight-line job.
        clear_log();
        mem_ready_in = 1'b0;
        start_job(10'h040, 10'd8);
        check("ovf_clear_on_start", 128'(overflow_out), 128'(0));
        push_lines(4, 20);
        check("ovf_pre", 128'(overflow_out), 128'(0));
        push_lines(1, 24);
        check("ovf_set", 128'(overflow_out), 128'(1));
        check("ovf_count", 128'(fifo_count_out), 128'(4));
        mem_ready_in = 1'b1;
        ticks(6);
        check("ovf_sticky", 128'(overflow_out), 128'(1));
        check("ovf_busy", 128'(busy_out), 128'(1));
        check("ovf_drained", 128'(fifo_count_out), 128'(0));
        check("ovf_ndone", 128'(done_cnt), 128'(0));
        check_writes("ovf", 10'h040, 4, 20);
        do_reset();
        check_idle_outputs("ovf_reset");

        // Full FIFO with simultaneous push and pop.
        clear_log();
        mem_ready_in = 1'b0;
        start_job(10'h080, 10'd6);
        push_lines(4, 30);
        mem_ready_in = 1'b1;
        push_lines(1, 34);
        check("pp_count", 128'(fifo_count_out), 128'(4));
        check("pp_ovf", 128'(overflow_out), 128'(0));
        push_lines(1, 35);
        check("pp_count2", 128'(fifo_count_out), 128'(4));
        ticks(4);
        check("pp_done", 128'(done_out), 128'(1));
        tick();
        check("pp_ovf_end", 128'(overflow_out), 128'(0));
        check_writes("pp", 10'h080, 6, 30);

        // Zero-length job.
        clear_log();
        start_job(10'h055, 10'd0);
        check("zero_done", 128'(done_out), 128'(1));
        check("zero_we", 128'(mem_we_out), 128'(0));
        check("zero_busy", 128'(busy_out), 128'(0));
        tick();
        check("zero_done_gone", 128'(done_out), 128'(0));
        check("zero_nwr", 128'(wr_addr_q.size()), 128'(0));

        // Address wrap-around.
        clear_log();
        mem_ready_in = 1'b1;
        start_job(10'h3FE, 10'd3);
        push_lines(3, 40);
        ticks(3);
        check("wrap_ndone", 128'(done_cnt), 128'(1));
        check("wrap_a0", 128'(wr_addr_q.size() > 0 ? wr_addr_q[0] : 10'h1), 128'(10'h3FE));
        check("wrap_a1", 128'(wr_addr_q.size() > 1 ? wr_addr_q[1] : 10'h1), 128'(10'h3FF));
        check("wrap_a2", 128'(wr_addr_q.size() > 2 ? wr_addr_q[2] : 10'h1), 128'(10'h000));
        check("wrap_nwr", 128'(wr_addr_q.size()), 128'(3));

        // Lines arriving while idle are discarded silently.
        clear_log();
        push_lines(2, 50);
        check("idle_count", 128'(fifo_count_out), 128'(0));
        check("idle_we", 128'(mem_we_out), 128'(0));
        check("idle_ovf", 128'(overflow_out), 128'(0));
        tick();
        check("idle_nwr", 128'(wr_addr_q.size()), 128'(0));

        // Reset mid-job after two of four writes, then a fresh job.
        clear_log();
        start_job(10'h030, 10'd4);
        push_lines(3, 60);
        check("mid_two_written", 128'(wr_addr_q.size()), 128'(2));
        do_reset();
        check_idle_outputs("mid_reset");
        clear_log();
        start_job(10'h020, 10'd2);
        push_lines(2, 70);
        ticks(3);
        check("mid_ndone", 128'(done_cnt), 128'(1));
        check_writes("mid_new", 10'h020, 2, 70);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
